// File: rtl/alu_share_arbiter_if.sv
// Operand/result handshake bundle between two clients and the shared ALU.
// The master modport is the client side, the slave modport is the arbiter.
interface alu_share_arbiter_if #(
  parameter int W  = 4,
  parameter int OW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;
  logic [1:0]    req0_op;
  logic          req1_valid;
  logic          req1_ready;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;
  logic [1:0]    req1_op;
  logic          resp0_valid;
  logic          resp0_ready;
  logic          resp1_valid;
  logic          resp1_ready;
  logic [OW-1:0] resp_data;
  logic          busy;
  logic          owner;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_data, busy, owner
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_data, busy, owner
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one four-op ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold until taken).
module alu_share_arbiter #(
  parameter int W  = 4,
  parameter int OW = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         next;
  logic           prio;
  logic           owner;
  logic           grant0;
  logic           grant1;
  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic [1:0]     op_p0;
  logic [OW-1:0]  data_p1;

  // Operands are zero-extended so add keeps its carry and multiply its full product.
  function automatic logic [OW-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op);
    logic [OW-1:0] ax;
    logic [OW-1:0] bx;
    ax = {{(OW-W){1'b0}}, a};
    bx = {{(OW-W){1'b0}}, b};
    case (op)
      2'b00:   return ax + bx;
      2'b01:   return ax * bx;
      2'b10:   return ax | bx;
      default: return ax & bx;
    endcase
  endfunction

  always_comb begin
    next   = state;
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || !prio)) grant0 = 1'b1;
        else if (bus.req1_valid)                          grant1 = 1'b1;
        if (grant0 || grant1) next = EXEC;
      end
      EXEC: next = RESP;
      RESP: if (owner ? bus.resp1_ready : bus.resp0_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= next;
      if (grant0 || grant1) begin
        owner <= grant1;
        prio  <= ~grant1;
      end
    end
  end

  // Stage p0: winner's operands captured on the grant edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
    end else if (grant0) begin
      a_p0  <= bus.req0_a;
      b_p0  <= bus.req0_b;
      op_p0 <= bus.req0_op;
    end else if (grant1) begin
      a_p0  <= bus.req1_a;
      b_p0  <= bus.req1_b;
      op_p0 <= bus.req1_op;
    end
  end

  // Stage p1: registered result, held through RESP and after the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              data_p1 <= '0;
    else if (state == EXEC) data_p1 <= alu(a_p0, b_p0, op_p0);
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = (state == RESP) && !owner;
  assign bus.resp1_valid = (state == RESP) && owner;
  assign bus.resp_data   = data_p1;
  assign bus.busy        = (state != IDLE);
  assign bus.owner       = owner;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 4-bit, four-op ALU between two requesters using a round-robin arbiter and a three-state sequencer. Each requester has a valid/ready operand channel and a valid/ready result channel. Only one operation is in flight at a time: accept, then execute into a registered result, then hold the result until the owning requester takes it. The block sits between two client datapaths and the shared arithmetic resource, and replaces per-client register/ALU copies.

Parameters:
W, 4, operand width of A and B.
OW, 8, result width; must equal 2*W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (0 = reset)
req0_valid  in  1  requester 0 presents an operation
req0_ready  out  1  requester 0's operation is accepted this cycle
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req0_op  in  2  requester 0 opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
resp0_valid  out  1  result for requester 0 is available
resp0_ready  in  1  requester 0 takes the result
resp1_valid  out  1  result for requester 1 is available
resp1_ready  in  1  requester 1 takes the result
resp_data  out  OW  shared result bus; valid only while respN_valid is high
busy  out  1  high in EXEC and RESP
owner  out  1  index of the requester that owns the current or last operation

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; prio=0 (requester 0 preferred); owner=0; resp_data=0; latched operands and op=0. All valid/ready outputs=0; busy=0.
- A reset mid-operation discards the in-flight operation. No response is issued for it.
- States are IDLE, EXEC and RESP.
- IDLE:
  - reqN_ready is combinational and equals grantN.
  - Only one valid: grant that requester.
  - Both valid: grant requester prio.
  - Neither valid: stay in IDLE; both ready=0.
  - On the edge with a grant: latch a, b and op of the winner; owner<=winner; prio<=~winner; go to EXEC.
- EXEC (1 cycle):
  - Compute on the latched operands; resp_data<=result; go to RESP.
  - reqN_ready=0.
- RESP:
  - resp[owner]_valid=1 and held; the other resp valid=0; resp_data is held stable.
  - On the edge with resp[owner]_ready=1: go to IDLE. resp_data keeps its value; only the valid drops.
  - resp_ready from the non-owner is ignored.
  - No new operation is accepted in RESP. The next grant happens at earliest the cycle after the handshake, so back-to-back throughput is one operation per 3 cycles.
- Latency: accept at edge T → resp_valid high in cycle T+2, after the EXEC edge at T+1.
- Opcode, with operands zero-extended to OW and the result OW bits:
  - 00: A+B (carry kept in bit W)
  - 01: A*B (full product)
  - 10: A|B
  - 11: A&B
- Fairness: under continuous requests from both, grants alternate 0,1,0,1… A lone requester can be granted repeatedly; prio still toggles to the non-winner after each grant.
- Inputs of a non-granted requester may change freely. Requester inputs are sampled only on the grant edge.
- A requester that drops valid before being granted is never served (no latching of pending requests).
- busy=1 exactly in EXEC and RESP.

Test Plan:
- Reset, then req0_valid with a=4'd9, b=4'd7, op=00 → req0_ready=1 in that cycle; two cycles later resp0_valid=1, resp_data=8'd16, busy=1; with resp0_ready=1 → IDLE the next cycle, busy=0.
- Same-cycle requests: req0 15*15 (op=01) and req1 4'b1010|4'b0101 (op=10) both held valid → req0 granted first, resp_data=8'd225; then req1 granted, resp_data=8'h0F; owner sequence 0,1.
- Continuous requests from both for 6 operations, resp_ready tied to 1 → grants alternate 0,1,0,1,0,1; each accept 3 cycles apart; op=11 with a=4'hC, b=4'hA yields 8'h08.
- Back-pressure: hold resp1_ready=0 for 5 cycles in RESP while req0_valid=1 → resp1_valid and resp_data remain stable, req0_ready=0 throughout, and resp0_ready pulses are ignored; release → req0 granted the cycle after the handshake.
- Reset asserted (rst=0) during EXEC of req1 → all outputs 0 immediately (asynchronously, not waiting for a clock edge); after release, no resp1_valid appears and prio=0.
- Lone requester: req1 issues 3 ops 4'hF+4'hF → each result 8'd30, granted every 3 cycles; req0_ready stays 0.
